// File: rtl/branch_pkg.sv
// Purpose : shared types and helpers for the branch resolution/prediction unit.
// Latency : n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: funct3_e (B-type conditions), bht_ctr_t (2-bit saturating counter),
//           BHT_RESET_CTR, ctr_next() saturating counter step.
package branch_pkg;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,  // strong not-taken
    CTR_WNT = 2'b01,  // weak not-taken
    CTR_WT  = 2'b10,  // weak taken
    CTR_ST  = 2'b11   // strong taken
  } bht_ctr_t;

  localparam bht_ctr_t BHT_RESET_CTR = CTR_WNT;

  // Saturating step toward the resolved outcome.
  function automatic bht_ctr_t ctr_next(input bht_ctr_t c, input logic taken);
    bht_ctr_t r;
    r = c;
    case (c)
      CTR_SNT: r = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: r = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  r = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  r = taken ? CTR_ST  : CTR_WT;
      default: r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Purpose : decode a B-type funct3 plus comparator flags into the branch outcome.
// Latency : purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs every cycle.
// Ports   : funct3, br_less, br_equal in; taken, br_un (1 = signed compare),
//           illegal (funct3 010/011) out.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_less,
  input  logic       br_equal,
  output logic       taken,
  output logic       br_un,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    br_un   = 1'b1;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = br_equal;
      F3_BNE:  taken = ~br_equal;
      F3_BLT:  taken = br_less;
      F3_BGE:  taken = ~br_less;
      F3_BLTU: begin taken = br_less;  br_un = 1'b0; end
      F3_BGEU: begin taken = ~br_less; br_un = 1'b0; end
      default: illegal = 1'b1;  // 010 / 011 have no B-type meaning
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Purpose : resolve EX branches, flag mispredicts, keep a 2-bit-counter BHT read at fetch.
// Latency : resolution is combinational; a BHT update is visible at fetch the cycle after its edge.
// Backpressure: none; one branch per cycle is always accepted.
// Ports   : i_clk, i_reset (async, active-high); i_fetch_pc -> o_pred_taken;
//           i_ex_valid, i_ex_pc, i_funct3, i_br_less, i_br_equal, i_ex_pred_taken ->
//           o_br_un, o_taken, o_mispredict, o_illegal; o_branch_cnt, o_mispred_cnt.
// Option  : define BPU_PERF_EN to build the saturating performance counters;
//           otherwise both counter ports are tied to 0.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [XLEN-1:0]  i_fetch_pc,
  output logic             o_pred_taken,
  input  logic             i_ex_valid,
  input  logic [XLEN-1:0]  i_ex_pc,
  input  logic [2:0]       i_funct3,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  input  logic             i_ex_pred_taken,
  output logic             o_br_un,
  output logic             o_taken,
  output logic             o_mispredict,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  bht_ctr_t          bht [BHT_DEPTH];
  logic [IDX_W-1:0]  fetch_idx;
  logic [IDX_W-1:0]  ex_idx;
  logic              cond_taken;
  logic              cond_illegal;
  logic              active;
  logic              update_en;
  logic              unused_pc_bits;

  // Word-aligned PCs: drop the byte offset, keep IDX_W bits (aliasing allowed).
  assign fetch_idx = i_fetch_pc[IDX_W+1:2];
  assign ex_idx    = i_ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{i_fetch_pc[XLEN-1:IDX_W+2], i_fetch_pc[1:0],
                            i_ex_pc[XLEN-1:IDX_W+2], i_ex_pc[1:0]};

  branch_cond_eval u_cond (
    .funct3   (i_funct3),
    .br_less  (i_br_less),
    .br_equal (i_br_equal),
    .taken    (cond_taken),
    .br_un    (o_br_un),
    .illegal  (cond_illegal)
  );

  assign active       = i_ex_valid & ~i_reset;
  assign o_taken      = active & cond_taken;
  assign o_illegal    = active & cond_illegal;
  assign o_mispredict = active & ~cond_illegal & (cond_taken ^ i_ex_pred_taken);

  // Reset gating is handled by the async reset branch of the BHT register.
  assign update_en = i_ex_valid & ~cond_illegal;

  // Combinational read of the registered array gives read-before-write on a
  // same-cycle fetch/EX index collision.
  assign o_pred_taken = ~i_reset & bht[fetch_idx][1];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= BHT_RESET_CTR;
      end
    end else if (update_en) begin
      bht[ex_idx] <= ctr_next(bht[ex_idx], cond_taken);
    end
  end

`ifdef BPU_PERF_EN
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (update_en && (branch_cnt != '1)) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (o_mispredict && (mispred_cnt != '1)) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

  assign o_branch_cnt  = branch_cnt;
  assign o_mispred_cnt = mispred_cnt;
`else
  assign o_branch_cnt  = '0;
  assign o_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Purpose : self-checking bench for branch_predict_unit: directed scenarios then random traffic,
//           expected responses queued by the driver and compared by an independent monitor.
// Latency : one record per clock; monitor compares at the falling edge.
// Backpressure: n/a.
module tb_branch_predict_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [XLEN-1:0] fetch_pc = '0;
  logic            pred_taken;
  logic            ex_valid = 1'b0;
  logic [XLEN-1:0] ex_pc = '0;
  logic [2:0]      funct3 = 3'b000;
  logic            br_less = 1'b0;
  logic            br_equal = 1'b0;
  logic            ex_pred_taken = 1'b0;
  logic            br_un;
  logic            taken;
  logic            mispredict;
  logic            illegal;
  logic [CW-1:0]   branch_cnt;
  logic [CW-1:0]   mispred_cnt;

  always #5 clk = ~clk;

  branch_predict_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_fetch_pc      (fetch_pc),
    .o_pred_taken    (pred_taken),
    .i_ex_valid      (ex_valid),
    .i_ex_pc         (ex_pc),
    .i_funct3        (funct3),
    .i_br_less       (br_less),
    .i_br_equal      (br_equal),
    .i_ex_pred_taken (ex_pred_taken),
    .o_br_un         (br_un),
    .o_taken         (taken),
    .o_mispredict    (mispredict),
    .o_illegal       (illegal),
    .o_branch_cnt    (branch_cnt),
    .o_mispred_cnt   (mispred_cnt)
  );

  typedef struct {
    int  step;
    logic pred, brun, tk, misp, ill;
    int  bcnt, mcnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   step_no = 0;

  // Reference model: counter strength 0..3 per entry, plain integer counts.
  int ctr [DEPTH];
  int m_bcnt;
  int m_mcnt;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ctr[i] = 1;
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  task automatic check(input string name, input int s, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s step=%0d got=%0d want=%0d", name, s, act, req);
    end
  endtask

  // Monitor: every falling edge with a pending expectation, compare all outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pred_taken", e.step, int'(pred_taken), int'(e.pred));
      check("br_un",      e.step, int'(br_un),      int'(e.brun));
      check("taken",      e.step, int'(taken),      int'(e.tk));
      check("mispredict", e.step, int'(mispredict), int'(e.misp));
      check("illegal",    e.step, int'(illegal),    int'(e.ill));
      check("branch_cnt", e.step, int'(branch_cnt), e.bcnt);
      check("mispred_cnt",e.step, int'(mispred_cnt),e.mcnt);
    end
  end

  // One clock of stimulus: drive, predict from the model, queue, then advance the model.
  task automatic step(input logic v, input logic [31:0] epc, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input logic ptk,
                      input logic [31:0] fpc, input logic r);
    exp_t e;
    bit signed_mode, legal, tk, lt;
    int fi, ei;
    signed_mode = !(f3 == 3'd6 || f3 == 3'd7);
    legal       = !(f3 == 3'd2 || f3 == 3'd3);
    lt = signed_mode ? ($signed(a) < $signed(b)) : (a < b);
    case (f3)
      3'd0: tk = (a == b);
      3'd1: tk = (a != b);
      3'd4: tk = ($signed(a) <  $signed(b));
      3'd5: tk = ($signed(a) >= $signed(b));
      3'd6: tk = (a <  b);
      3'd7: tk = (a >= b);
      default: tk = 1'b0;
    endcase
    rst = r; ex_valid = v; ex_pc = epc; funct3 = f3;
    br_less = lt; br_equal = (a == b); ex_pred_taken = ptk; fetch_pc = fpc;
    fi = int'((fpc >> 2) % DEPTH);
    ei = int'((epc >> 2) % DEPTH);
    if (r) model_reset();
    e.step = step_no;
    e.brun = signed_mode;
    e.pred = !r && (ctr[fi] >= 2);
    e.tk   = !r && v && legal && tk;
    e.misp = !r && v && legal && (tk != ptk);
    e.ill  = !r && v && !legal;
`ifdef BPU_PERF_EN
    e.bcnt = m_bcnt;
    e.mcnt = m_mcnt;
`else
    e.bcnt = 0;
    e.mcnt = 0;
`endif
    exp_q.push_back(e);
    if (!r && v && legal) begin
      ctr[ei] = tk ? ((ctr[ei] == 3) ? 3 : ctr[ei] + 1) : ((ctr[ei] == 0) ? 0 : ctr[ei] - 1);
      if (m_bcnt < CMAX) m_bcnt++;
      if (tk != ptk && m_mcnt < CMAX) m_mcnt++;
    end
    step_no++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    // 1. Reset state and fetch after reset.
    step(0, 0, 3'd0, 0, 0, 0, 32'h40, 1);
    step(0, 0, 3'd0, 0, 0, 0, 32'h40, 0);
    // 2. BEQ taken, predicted not-taken, then read back and saturate.
    step(1, 32'h40, 3'd0, 5, 5, 0, 32'h40, 0);
    step(0, 0, 3'd0, 0, 0, 0, 32'h40, 0);
    step(1, 32'h40, 3'd0, 7, 7, 1, 32'h40, 0);
    step(1, 32'h40, 3'd0, 7, 7, 1, 32'h40, 0);
    step(0, 0, 3'd0, 0, 0, 0, 32'h40, 0);
    // 3. Aliasing: 0x140 shares idx with 0x40; 0x44 does not.
    step(0, 0, 3'd0, 0, 0, 0, 32'h140, 0);
    step(0, 0, 3'd0, 0, 0, 0, 32'h44, 0);
    // 4. BGEU unsigned and BLT signed.
    step(1, 32'h80, 3'd7, 32'hFFFF_FFFF, 1, 0, 32'h80, 0);
    step(1, 32'h84, 3'd4, 32'hFFFF_FFFF, 1, 1, 32'h84, 0);
    // 5. Illegal funct3, and same-cycle fetch/EX on idx 16 (read-before-write).
    step(1, 32'h40, 3'd2, 3, 3, 1, 32'h40, 0);
    step(1, 32'h40, 3'd1, 3, 3, 0, 32'h40, 0);
    step(1, 32'h40, 3'd1, 3, 3, 0, 32'h40, 0);
    step(0, 0, 3'd0, 0, 0, 0, 32'h40, 0);
    // Reset after training: trained entries return to weak not-taken.
    step(0, 0, 3'd0, 0, 0, 0, 32'h40, 1);
    step(0, 0, 3'd0, 0, 0, 0, 32'h40, 0);
    step(0, 0, 3'd0, 0, 0, 0, 32'h84, 0);
    // 6. 20 valid branches, 7 mispredicted: branch count saturates.
    for (int i = 0; i < 20; i++) begin
      step(1, 32'h100 + 32'(i * 4), 3'd0, 1, 1, (i < 7) ? 1'b0 : 1'b1, 32'h0, 0);
    end
    step(0, 0, 3'd0, 0, 0, 0, 32'h0, 0);
    // Random traffic on a small PC window, occasional reset.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b, epc, fpc;
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      epc = {$urandom_range(0, 7), 23'd0, 2'(0)} | (32'($urandom_range(0, 127)) << 2);
      fpc = {$urandom_range(0, 7), 23'd0, 2'(0)} | (32'($urandom_range(0, 127)) << 2);
      step(1'($urandom_range(0, 3) != 0), epc, 3'($urandom_range(0, 7)), a, b,
           1'($urandom_range(0, 1)), fpc, 1'($urandom_range(0, 60) == 0));
    end
    step(0, 0, 3'd0, 0, 0, 0, 32'h0, 0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
